// File: rtl/decoupled_queue.sv
// rtl/decoupled_queue.sv - parametrised valid/ready queue with optional pipe and flow modes
//
// Purpose: buffers up to DEPTH items between a producer and a consumer.
//   PIPE=1 lets a full queue accept an item in the same cycle one leaves.
//   FLOW=1 lets an item pass straight from enq to deq while the queue is empty.
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset (clears pointers and count only)
//   enq_data   producer payload
//   enq_valid  producer has an item
//   enq_ready  queue can take the item this cycle
//   deq_data   consumer payload
//   deq_valid  queue (or flow-through) has an item
//   deq_ready  consumer takes the item this cycle
//   count      stored entries, 0..DEPTH; flow-through items are not counted
module decoupled_queue #(
   parameter int DATA_W = 1,
   parameter int DEPTH  = 2,
   parameter bit PIPE   = 1'b0,
   parameter bit FLOW   = 1'b0,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] enq_data,
   input  logic              enq_valid,
   output logic              enq_ready,
   output logic [DATA_W-1:0] deq_data,
   output logic              deq_valid,
   input  logic              deq_ready,
   output logic [CNT_W-1:0]  count
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic empty;
   logic full;
   logic fire_enq;
   logic fire_deq;
   logic pass_thru;
   logic wr_en;
   logic rd_en;

   always_comb begin
      empty     = (count_q == '0);
      full      = (count_q == CNT_W'(DEPTH));
      enq_ready = !full || (PIPE && deq_ready);
      deq_valid = !empty || (FLOW && enq_valid);
      deq_data  = (FLOW && empty) ? enq_data : mem_q[head_q];

      fire_enq  = enq_valid && enq_ready;
      fire_deq  = deq_valid && deq_ready;

      // A flow-through item never touches storage.
      pass_thru = FLOW && empty && fire_enq && fire_deq;
      wr_en     = fire_enq && !pass_thru;
      rd_en     = fire_deq && !pass_thru;

      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);

      // Explicit wrap so non-power-of-two depths work.
      if (wr_en) begin
         tail_d = (tail_q == PTR_W'(DEPTH - 1)) ? '0 : tail_q + PTR_W'(1);
      end
      if (rd_en) begin
         head_d = (head_q == PTR_W'(DEPTH - 1)) ? '0 : head_q + PTR_W'(1);
      end

      count = count_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Payload storage is deliberately not reset. When full with PIPE the write
   // lands in the slot being read this same cycle (tail == head).
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[tail_q] <= enq_data;
      end
   end

`ifndef SYNTHESIS
   a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
      count_q <= CNT_W'(DEPTH));
   a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(rd_en && empty));
   a_enq_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (enq_valid && !enq_ready) |=> (enq_valid && $stable(enq_data)));
   a_deq_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (deq_valid && !deq_ready && !empty) |=> (deq_valid && $stable(deq_data)));
`endif

endmodule

// File: tb/tb_decoupled_queue.sv
// tb/tb_decoupled_queue.sv - scoreboard bench for decoupled_queue
module tb_decoupled_queue;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // a: DEPTH=3 plain; p: DEPTH=1 PIPE; f: DEPTH=2 FLOW
   logic [7:0] a_enq_data = '0, a_deq_data;
   logic       a_enq_valid = 1'b0, a_enq_ready, a_deq_valid, a_deq_ready = 1'b0;
   logic [1:0] a_count;
   logic [7:0] p_enq_data = '0, p_deq_data;
   logic       p_enq_valid = 1'b0, p_enq_ready, p_deq_valid, p_deq_ready = 1'b0;
   logic [0:0] p_count;
   logic [7:0] f_enq_data = '0, f_deq_data;
   logic       f_enq_valid = 1'b0, f_enq_ready, f_deq_valid, f_deq_ready = 1'b0;
   logic [1:0] f_count;

   decoupled_queue #(.DATA_W(8), .DEPTH(3), .PIPE(1'b0), .FLOW(1'b0)) u_a (
      .clk(clk), .rst_n(rst_n),
      .enq_data(a_enq_data), .enq_valid(a_enq_valid), .enq_ready(a_enq_ready),
      .deq_data(a_deq_data), .deq_valid(a_deq_valid), .deq_ready(a_deq_ready),
      .count(a_count));

   decoupled_queue #(.DATA_W(8), .DEPTH(1), .PIPE(1'b1), .FLOW(1'b0)) u_p (
      .clk(clk), .rst_n(rst_n),
      .enq_data(p_enq_data), .enq_valid(p_enq_valid), .enq_ready(p_enq_ready),
      .deq_data(p_deq_data), .deq_valid(p_deq_valid), .deq_ready(p_deq_ready),
      .count(p_count));

   decoupled_queue #(.DATA_W(8), .DEPTH(2), .PIPE(1'b0), .FLOW(1'b1)) u_f (
      .clk(clk), .rst_n(rst_n),
      .enq_data(f_enq_data), .enq_valid(f_enq_valid), .enq_ready(f_enq_ready),
      .deq_data(f_deq_data), .deq_valid(f_deq_valid), .deq_ready(f_deq_ready),
      .count(f_count));

   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] a_sb[$];
   logic [7:0] p_sb[$];
   logic [7:0] f_sb[$];
   int a_popped = 0;
   int p_popped = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: push on accepted enqueue, pop and compare on accepted dequeue.
   always @(negedge clk) begin
      if (!rst_n) begin
         a_sb.delete();
         p_sb.delete();
         f_sb.delete();
      end else begin
         if (a_enq_valid && a_enq_ready) a_sb.push_back(a_enq_data);
         if (p_enq_valid && p_enq_ready) p_sb.push_back(p_enq_data);
         if (f_enq_valid && f_enq_ready) f_sb.push_back(f_enq_data);
         if (a_deq_valid && a_deq_ready) begin
            a_popped++;
            if (a_sb.size() == 0) check_eq("a_underrun", 1, 0);
            else check_eq("a_data", {24'h0, a_deq_data}, {24'h0, a_sb.pop_front()});
         end
         if (p_deq_valid && p_deq_ready) begin
            p_popped++;
            if (p_sb.size() == 0) check_eq("p_underrun", 1, 0);
            else check_eq("p_data", {24'h0, p_deq_data}, {24'h0, p_sb.pop_front()});
         end
         if (f_deq_valid && f_deq_ready) begin
            if (f_sb.size() == 0) check_eq("f_underrun", 1, 0);
            else check_eq("f_data", {24'h0, f_deq_data}, {24'h0, f_sb.pop_front()});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int sent;
      int popped0;
      logic fired;

      // Reset state, before any clock edge.
      #3;
      check_eq("rst_a_enq_ready", a_enq_ready, 1);
      check_eq("rst_a_deq_valid", a_deq_valid, 0);
      check_eq("rst_a_count", a_count, 0);
      check_eq("rst_p_enq_ready", p_enq_ready, 1);
      check_eq("rst_f_deq_valid", f_deq_valid, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Fill DEPTH=3 with consumer stalled, 4th item must wait.
      a_deq_ready = 1'b0;
      a_enq_valid = 1'b1;
      a_enq_data = 8'h0A; tick(); check_eq("fill_cnt1", a_count, 1);
      a_enq_data = 8'h0B; tick(); check_eq("fill_cnt2", a_count, 2);
      a_enq_data = 8'h0C; tick(); check_eq("fill_cnt3", a_count, 3);
      check_eq("fill_full_rdy", a_enq_ready, 0);
      a_enq_data = 8'h0D; tick();
      check_eq("fill_4th_cnt", a_count, 3);
      check_eq("fill_4th_rdy", a_enq_ready, 0);
      check_eq("fill_head", a_deq_data, 8'h0A);
      a_deq_ready = 1'b1;
      tick(); check_eq("drain_cnt_a", a_count, 2);
      check_eq("drain_rdy", a_enq_ready, 1);
      tick(); a_enq_valid = 1'b0;
      check_eq("drain_cnt_b", a_count, 2);
      tick(); check_eq("drain_cnt_c", a_count, 1);
      check_eq("drain_4th", a_deq_data, 8'h0D);
      tick(); check_eq("drain_cnt_d", a_count, 0);
      check_eq("drain_valid", a_deq_valid, 0);

      // Wrap-around with random valid/ready.
      sent = 0;
      popped0 = a_popped;
      for (int cyc = 0; cyc < 400 && (sent < 10 || a_count != 0); cyc++) begin
         if (!a_enq_valid && sent < 10 && $urandom_range(0, 1) == 1) begin
            a_enq_valid = 1'b1;
            a_enq_data = 8'h10 + 8'(sent);
         end
         a_deq_ready = ($urandom_range(0, 2) != 0);
         @(negedge clk);
         fired = a_enq_valid && a_enq_ready;
         tick();
         if (fired) begin
            a_enq_valid = 1'b0;
            sent++;
         end
      end
      a_deq_ready = 1'b0;
      check_eq("wrap_sent", sent, 10);
      check_eq("wrap_popped", a_popped - popped0, 10);
      check_eq("wrap_cnt", a_count, 0);

      // FLOW DEPTH=2: stalled consumer stores the item, then enq+deq at count=1.
      f_deq_ready = 1'b0;
      f_enq_valid = 1'b1; f_enq_data = 8'h21;
      tick(); check_eq("flow_store_cnt", f_count, 1);
      f_deq_ready = 1'b1;
      f_enq_data = 8'h22; tick();
      check_eq("simul_cnt_a", f_count, 1);
      check_eq("simul_data_a", f_deq_data, 8'h22);
      f_enq_data = 8'h23; tick();
      check_eq("simul_cnt_b", f_count, 1);
      check_eq("simul_data_b", f_deq_data, 8'h23);
      f_enq_valid = 1'b0; tick();
      check_eq("simul_cnt_c", f_count, 0);
      // Pass-through while empty.
      f_enq_valid = 1'b1; f_enq_data = 8'h05;
      #1;
      check_eq("flow_valid", f_deq_valid, 1);
      check_eq("flow_data", f_deq_data, 8'h05);
      check_eq("flow_cnt_now", f_count, 0);
      tick(); f_enq_valid = 1'b0;
      check_eq("flow_cnt_next", f_count, 0);
      f_deq_ready = 1'b0;

      // PIPE DEPTH=1: full rate streaming.
      p_deq_ready = 1'b0;
      p_enq_valid = 1'b1; p_enq_data = 8'd1;
      tick();
      check_eq("pipe_cnt_full", p_count, 1);
      check_eq("pipe_rdy_stall", p_enq_ready, 0);
      p_deq_ready = 1'b1;
      #1;
      check_eq("pipe_rdy_full", p_enq_ready, 1);
      for (int i = 2; i <= 8; i++) begin
         p_enq_data = 8'(i);
         check_eq("pipe_stream_rdy", p_enq_ready, 1);
         tick();
         check_eq("pipe_stream_cnt", p_count, 1);
      end
      p_enq_valid = 1'b0;
      tick();
      check_eq("pipe_end_cnt", p_count, 0);
      check_eq("pipe_popped", p_popped, 8);
      p_deq_ready = 1'b0;

      // Asynchronous reset with two items stored.
      a_deq_ready = 1'b0;
      a_enq_valid = 1'b1;
      a_enq_data = 8'h31; tick();
      a_enq_data = 8'h32; tick();
      a_enq_valid = 1'b0;
      check_eq("arst_pre_cnt", a_count, 2);
      check_eq("arst_pre_valid", a_deq_valid, 1);
      #1;
      rst_n = 1'b0;
      #1;
      check_eq("arst_valid", a_deq_valid, 0);
      check_eq("arst_cnt", a_count, 0);
      check_eq("arst_rdy", a_enq_ready, 1);
      tick();
      rst_n = 1'b1;
      a_enq_valid = 1'b1; a_enq_data = 8'h41;
      tick();
      a_enq_valid = 1'b0;
      check_eq("post_rst_cnt", a_count, 1);
      check_eq("post_rst_head", a_deq_data, 8'h41);
      a_deq_ready = 1'b1;
      tick();
      check_eq("post_rst_empty", a_count, 0);
      check_eq("sb_a_left", a_sb.size(), 0);
      check_eq("sb_f_left", f_sb.size(), 0);
      a_deq_ready = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
